rx_chan_arbiter: RTL and testbench

RX_CHAN_ARBITER -- requirements
Module: rx_chan_arbiter

---
 rtl/rx_chan_arbiter.sv | 157 +++++++++++++++
 tb/tb_rx_chan_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_chan_arbiter.sv
// rx_chan_arbiter
//   Merges NUM_CH AXI-Stream RX channels into one stream, one whole packet
//   at a time. A round-robin search picks the next requester after the
//   channel that last finished a packet. The grant is held until that
//   channel's tlast has been accepted. The output beat is registered, so
//   the latency from input handshake to output beat is one cycle.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   s_axis_tdata    : NUM_CH*DWIDTH, channel c in [c*DWIDTH +: DWIDTH]
//   s_axis_tkeep    : NUM_CH*DWIDTH/8, channel c in [c*DWIDTH/8 +: DWIDTH/8]
//   s_axis_tlast    : per-channel end of packet
//   s_axis_tvalid   : per-channel beat valid
//   s_axis_tready   : per-channel ready (only the granted channel can see 1)
//   ch_enable       : channel may win new grants when 1
//   m_axis_tdata    : merged data
//   m_axis_tkeep    : merged keep (passed through untouched)
//   m_axis_tlast    : merged end of packet
//   m_axis_tvalid   : merged beat valid
//   m_axis_tid      : source channel of the current output beat
//   m_axis_tready   : downstream ready
module rx_chan_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 240,
  localparam int IDW   = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
  localparam int KW    = DWIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH*KW-1:0]     s_axis_tkeep,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [DWIDTH-1:0]        m_axis_tdata,
  output logic [KW-1:0]            m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  output logic [IDW-1:0]           m_axis_tid,
  input  logic                     m_axis_tready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [IDW-1:0]    g;
  logic [IDW-1:0]    ptr;

  logic [NUM_CH-1:0] req;
  logic [IDW-1:0]    pick;
  logic              req_any;

  logic [DWIDTH-1:0] g_data;
  logic [KW-1:0]     g_keep;
  logic              g_last;
  logic              g_valid;

  logic              out_ok;
  logic              grant_ok;
  logic              accept;

  assign req = s_axis_tvalid & ch_enable;

  // Round-robin search starting at ptr+1. The loop runs from the farthest
  // candidate down to the nearest so the nearest requester is written last
  // and wins, without needing an early exit.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    req_any = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (req[idx]) begin
        pick    = IDW'(idx);
        req_any = 1'b1;
      end
    end
  end

  // Channel-g view of the input bus
  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_last  = 1'b0;
    g_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (g == IDW'(c)) begin
        g_data  = s_axis_tdata[c*DWIDTH +: DWIDTH];
        g_keep  = s_axis_tkeep[c*KW +: KW];
        g_last  = s_axis_tlast[c];
        g_valid = s_axis_tvalid[c];
      end
    end
  end

  // The output register can take a new beat when it is empty or draining
  // this cycle. rst masks ready so that no beat is handshaken while the
  // arbiter is being reset.
  assign out_ok   = m_axis_tready | ~m_axis_tvalid;
  assign grant_ok = (state == LOCKED) & out_ok & ~rst;
  assign accept   = grant_ok & g_valid;

  always_comb begin
    s_axis_tready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_axis_tready[c] = grant_ok && (g == IDW'(c));
    end
  end

  // Arbitration state and output register. ptr resets to the last channel
  // so that channel 0 is first in the search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      g             <= '0;
      ptr           <= IDW'(NUM_CH - 1);
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            g     <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && g_last) begin
            ptr   <= g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        m_axis_tdata  <= g_data;
        m_axis_tkeep  <= g_keep;
        m_axis_tlast  <= g_last;
        m_axis_tvalid <= 1'b1;
        m_axis_tid    <= g;
      end else if (out_ok) begin
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tid    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_chan_arbiter.sv
// Directed testbench for rx_chan_arbiter (NUM_CH=4, DWIDTH=32).
// Each channel is fed by a simple packet source. The source advances when it
// sees a handshake. Each beat carries {A0+ch, packet#, beat#, 5A}.
module tb_rx_chan_arbiter;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC*DW-1:0] s_tdata;
  logic [NC*KW-1:0] s_tkeep;
  logic [NC-1:0]    s_tlast;
  logic [NC-1:0]    s_tvalid;
  logic [NC-1:0]    s_tready;
  logic [NC-1:0]    ch_en;
  logic [DW-1:0]    m_data;
  logic [KW-1:0]    m_keep;
  logic             m_last;
  logic             m_valid;
  logic [1:0]       m_tid;
  logic             m_tready;

  rx_chan_arbiter #(.NUM_CH(NC), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .ch_enable(ch_en),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tid(m_tid), .m_axis_tready(m_tready)
  );

  always #5 clk = ~clk;

  int len[NC];
  int pkts[NC];
  int beat[NC];
  int pno[NC];
  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] got_b;
  logic [39:0] exp_b;

  function automatic logic [DW-1:0] exp_data(int c, int p, int b);
    return {8'(8'hA0 + c), 8'(p), 8'(b), 8'h5A};
  endfunction

  function automatic logic [KW-1:0] exp_keep(bit last);
    return last ? 4'b0011 : 4'b1111;
  endfunction

  // Expected output beat packed as {valid, tid, tlast, tkeep, tdata}
  function automatic logic [39:0] exp_beat(int c, int p, int b, bit last);
    return {1'b1, 2'(c), last, exp_keep(last), exp_data(c, p, b)};
  endfunction

  task automatic drive_src();
    for (int c = 0; c < NC; c++) begin
      s_tvalid[c]          = (pkts[c] > 0);
      s_tlast[c]           = (beat[c] == len[c] - 1);
      s_tdata[c*DW +: DW]  = exp_data(c, pno[c], beat[c]);
      s_tkeep[c*KW +: KW]  = exp_keep(s_tlast[c]);
    end
  endtask

  task automatic clear_src();
    for (int c = 0; c < NC; c++) begin
      len[c] = 1; pkts[c] = 0; beat[c] = 0; pno[c] = 0;
    end
    drive_src();
  endtask

  // Advance one clock. The handshake is sampled at the falling edge, and
  // the sources are updated 1 time unit after the rising edge.
  task automatic tick();
    logic [NC-1:0] acc;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (acc[c]) begin
        beat[c]++;
        if (beat[c] == len[c]) begin
          beat[c] = 0; pno[c]++; pkts[c]--;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_tready = 1'b1; ch_en = '1;
    clear_src();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    got_b = {m_valid, m_tid, m_last, m_keep, m_data};
    n_checks++;
    if (got_b !== 40'h0) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", got_b, 40'h0);
    end
    n_checks++;
    if (s_tready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tready: got %b want 0000", s_tready);
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b0 || s_tready !== 4'b0000) begin
      n_fail++; $display("FAIL idle_quiet: got valid=%b tready=%b want 0/0000", m_valid, s_tready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    len[0] = 3; pkts[0] = 1;
    drive_src(); #1;
    n_checks++;
    if (s_tready !== 4'b0000) begin
      n_fail++; $display("FAIL basic_arb_cycle: got %b want 0000", s_tready);
    end
    tick();
    n_checks++;
    if (s_tready !== 4'b0001 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_grant: got tready=%b valid=%b want 0001/0", s_tready, m_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      got_b = {m_valid, m_tid, m_last, m_keep, m_data};
      exp_b = exp_beat(0, 0, k, k == 2);
      n_checks++;
      if (got_b !== exp_b) begin
        n_fail++; $display("FAIL basic_beat%0d: got %h want %h", k, got_b, exp_b);
      end
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_end: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NC; c++) begin
      len[c] = 1; pkts[c] = 3;
    end
    drive_src();
    for (int n = 1; n <= 24; n++) begin
      tick();
      got_b = {m_valid, m_tid, m_last, m_keep, m_data};
      if (n % 2 == 0) exp_b = exp_beat(((n / 2) - 1) % 4, ((n / 2) - 1) / 4, 0, 1'b1);
      else            exp_b = 40'h0;
      n_checks++;
      if (got_b !== exp_b) begin
        n_fail++; $display("FAIL rr_cycle%0d: got %h want %h", n, got_b, exp_b);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    len[1] = 4; pkts[1] = 1;
    drive_src();
    tick();
    tick();
    m_tready = 1'b0;
    len[0] = 1; pkts[0] = 1;
    drive_src(); #1;
    n_checks++;
    if (s_tready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_tready_drop: got %b want 0000", s_tready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      got_b = {m_valid, m_tid, m_last, m_keep, m_data};
      exp_b = exp_beat(1, 0, 0, 1'b0);
      n_checks++;
      if (got_b !== exp_b || s_tready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h tready=%b want %h tready=0000", k, got_b, s_tready, exp_b);
      end
    end
    m_tready = 1'b1; #1;
    n_checks++;
    if (s_tready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_resume: got %b want 0010", s_tready);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      got_b = {m_valid, m_tid, m_last, m_keep, m_data};
      exp_b = exp_beat(1, 0, k, k == 3);
      n_checks++;
      if (got_b !== exp_b) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h want %h", k, got_b, exp_b);
      end
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_gap: got valid=%b want 0", m_valid);
    end
    tick();
    got_b = {m_valid, m_tid, m_last, m_keep, m_data};
    exp_b = exp_beat(0, 0, 0, 1'b1);
    n_checks++;
    if (got_b !== exp_b) begin
      n_fail++; $display("FAIL bp_next_pkt: got %h want %h", got_b, exp_b);
    end
  endtask

  task automatic test_enable();
    do_reset();
    ch_en = 4'b1011;
    len[2] = 1; pkts[2] = 1;
    len[3] = 3; pkts[3] = 1;
    drive_src();
    tick();
    n_checks++;
    if (s_tready !== 4'b1000) begin
      n_fail++; $display("FAIL en_skip_disabled: got %b want 1000", s_tready);
    end
    ch_en = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      got_b = {m_valid, m_tid, m_last, m_keep, m_data};
      exp_b = exp_beat(3, 0, k, k == 2);
      n_checks++;
      if (got_b !== exp_b) begin
        n_fail++; $display("FAIL en_locked_beat%0d: got %h want %h", k, got_b, exp_b);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (m_valid !== 1'b0 || s_tready !== 4'b0000) begin
        n_fail++; $display("FAIL en_idle%0d: got valid=%b tready=%b want 0/0000", k, m_valid, s_tready);
      end
    end
    ch_en = 4'b0100;
    tick();
    n_checks++;
    if (s_tready !== 4'b0100) begin
      n_fail++; $display("FAIL en_reenable_grant: got %b want 0100", s_tready);
    end
    tick();
    got_b = {m_valid, m_tid, m_last, m_keep, m_data};
    exp_b = exp_beat(2, 0, 0, 1'b1);
    n_checks++;
    if (got_b !== exp_b) begin
      n_fail++; $display("FAIL en_reenable_beat: got %h want %h", got_b, exp_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    len[2] = 4; pkts[2] = 1;
    drive_src();
    tick();
    tick();
    tick();
    got_b = {m_valid, m_tid, m_last, m_keep, m_data};
    exp_b = exp_beat(2, 0, 1, 1'b0);
    n_checks++;
    if (got_b !== exp_b) begin
      n_fail++; $display("FAIL rstmid_beat2: got %h want %h", got_b, exp_b);
    end
    rst = 1'b1; m_tready = 1'b0;
    len[0] = 1; pkts[0] = 1;
    drive_src(); #1;
    n_checks++;
    if (s_tready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_tready_in_rst: got %b want 0000", s_tready);
    end
    tick();
    got_b = {m_valid, m_tid, m_last, m_keep, m_data};
    n_checks++;
    if (got_b !== 40'h0) begin
      n_fail++; $display("FAIL rstmid_out_cleared: got %h want %h", got_b, 40'h0);
    end
    rst = 1'b0; m_tready = 1'b1;
    tick();
    n_checks++;
    if (s_tready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_ch0_grant: got %b want 0001", s_tready);
    end
    tick();
    got_b = {m_valid, m_tid, m_last, m_keep, m_data};
    exp_b = exp_beat(0, 0, 0, 1'b1);
    n_checks++;
    if (got_b !== exp_b) begin
      n_fail++; $display("FAIL rstmid_ch0_beat: got %h want %h", got_b, exp_b);
    end
  endtask

  initial begin
    rst = 1'b1; m_tready = 1'b1; ch_en = '1;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test within 200000 time units");
    $fatal(1);
  end

endmodule
